// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result latch: FSM state encoding,
// ALU flag bit positions and the databus width.
package alu_pkg;

  // Databus width in bits; each transfer moves one byte.
  localparam int BUS_W = 8;

  // Bit positions inside alu_flags / flags_q.
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  // Transfer FSM states. ST_HI is only reachable when the high byte is enabled.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LO   = 2'd2,
    ST_HI   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_latch_grant_timer.sv
// grant_timer: counts cycles spent waiting for the databus grant and flags
// the cycle on which the wait limit is reached.
module grant_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count_reg;

  // Wait counter: clear has priority, otherwise count enabled cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= 8'h00;
    end else if (clr) begin
      count_reg <= 8'h00;
    end else if (en) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  // The TIMEOUT-th ungranted cycle is the abort cycle.
  assign expired = en && (count_reg == 8'(TIMEOUT - 1));

endmodule

// File: rtl/alu_latch.sv
// alu_latch: captures an ALU result and its flags, then requests the databus
// and drives the result out byte by byte (low byte first).
// Build option: define ALU_LATCH_HI_BYTE_EN to also store and transfer the
// high byte; without it only the low byte is stored and sent.
module alu_latch
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      alu_out,
  input  logic [3:0]       alu_flags,
  input  logic             latch_en,
  input  logic             bus_grant,
  output logic             bus_req,
  output logic             bus_oe,
  output logic [BUS_W-1:0] bus_data,
  output logic [3:0]       flags_q,
  output logic             busy,
  output logic             timeout,
  output logic             overrun
);

`ifdef ALU_LATCH_HI_BYTE_EN
  localparam int RES_W = 16;
`else
  localparam int RES_W = 8;
`endif

  state_t           state_reg;
  state_t           state_next;
  logic [RES_W-1:0] res_reg;
  logic [3:0]       flags_reg;
  logic             timeout_reg;
  logic             overrun_reg;
  logic             accept;
  logic             abort;
  logic             timer_clr;
  logic             timer_en;
  logic             timer_expired;

`ifndef ALU_LATCH_HI_BYTE_EN
  // High result byte is intentionally dropped in the single-byte build.
  logic [7:0] unused_hi;
  assign unused_hi = alu_out[15:8];
`endif

  // Wait counter runs only while requesting without a grant.
  assign timer_clr = (state_reg != ST_REQ) || bus_grant;
  assign timer_en  = (state_reg == ST_REQ) && !bus_grant;

  grant_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_grant_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and bus outputs decoded from the registered state.
  always_comb begin
    state_next = state_reg;
    bus_req    = 1'b0;
    bus_oe     = 1'b0;
    bus_data   = '0;
    accept     = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (latch_en) begin
          accept     = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        bus_req = 1'b1;
        if (bus_grant) begin
          state_next = ST_LO;
        end else if (timer_expired) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_LO: begin
        bus_req = 1'b1;
        bus_oe  = bus_grant;
        if (bus_grant) begin
          bus_data = res_reg[7:0];
`ifdef ALU_LATCH_HI_BYTE_EN
          state_next = ST_HI;
`else
          state_next = ST_IDLE;
`endif
        end
      end
      ST_HI: begin
`ifdef ALU_LATCH_HI_BYTE_EN
        bus_req = 1'b1;
        bus_oe  = bus_grant;
        if (bus_grant) begin
          bus_data   = res_reg[15:8];
          state_next = ST_IDLE;
        end
`else
        state_next = ST_IDLE;
`endif
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Result and flag capture, only on an accepted request in IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_reg   <= '0;
      flags_reg <= 4'h0;
    end else if (accept) begin
      res_reg   <= alu_out[RES_W-1:0];
      flags_reg <= alu_flags;
    end
  end

  // Status: one-cycle timeout pulse, sticky overrun cleared by a new capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timeout_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      timeout_reg <= abort;
      if (accept) begin
        overrun_reg <= 1'b0;
      end else if (latch_en && (state_reg != ST_IDLE)) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign busy    = (state_reg != ST_IDLE);
  assign flags_q = flags_reg;
  assign timeout = timeout_reg;
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_alu_latch.sv
// Self-checking bench for alu_latch: directed scenarios plus a randomized run
// checked cycle by cycle against a transaction-level reference model.
module tb_alu_latch;

  localparam int TO = 16;
  localparam int LOGN = 4096;
`ifdef ALU_LATCH_HI_BYTE_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic        clock;
  logic        reset;
  logic [15:0] alu_out;
  logic [3:0]  alu_flags;
  logic        latch_en;
  logic        bus_grant;
  logic        bus_req;
  logic        bus_oe;
  logic [7:0]  bus_data;
  logic [3:0]  flags_q;
  logic        busy;
  logic        timeout;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Per-cycle observation log.
  logic [7:0] obs_data  [0:LOGN-1];
  logic       obs_oe    [0:LOGN-1];
  logic       obs_req   [0:LOGN-1];
  logic       obs_busy  [0:LOGN-1];
  logic       obs_tout  [0:LOGN-1];
  logic       obs_over  [0:LOGN-1];
  logic [3:0] obs_flags [0:LOGN-1];

  // Reference model: 0 idle, 1 waiting for grant, 2 sending bytes.
  int         m_mode = 0;
  int         m_wait = 0;
  logic [7:0] m_q[$];
  logic [3:0] m_flags = 4'h0;
  logic       m_over = 1'b0;
  logic       m_tout = 1'b0;

  alu_latch #(.TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .alu_out   (alu_out),
    .alu_flags (alu_flags),
    .latch_en  (latch_en),
    .bus_grant (bus_grant),
    .bus_req   (bus_req),
    .bus_oe    (bus_oe),
    .bus_data  (bus_data),
    .flags_q   (flags_q),
    .busy      (busy),
    .timeout   (timeout),
    .overrun   (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_wait  = 0;
    m_q.delete();
    m_flags = 4'h0;
    m_over  = 1'b0;
    m_tout  = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge,
  // advance the model, then return just after the next rising edge.
  task automatic cycle(input logic le, input logic [15:0] a, input logic [3:0] f, input logic g);
    logic       e_busy;
    logic       e_oe;
    logic [7:0] e_data;
    latch_en  = le;
    alu_out   = a;
    alu_flags = f;
    bus_grant = g;
    @(negedge clock);
    e_busy = (m_mode != 0);
    e_oe   = (m_mode == 2) && g;
    e_data = e_oe ? m_q[0] : 8'h00;
    chk("busy", busy, e_busy);
    chk("bus_req", bus_req, e_busy);
    chk("bus_oe", bus_oe, e_oe);
    chk("bus_data", bus_data, e_data);
    chk("flags_q", flags_q, m_flags);
    chk("timeout", timeout, m_tout);
    chk("overrun", overrun, m_over);
    if (cyc < LOGN) begin
      obs_data[cyc]  = bus_data;
      obs_oe[cyc]    = bus_oe;
      obs_req[cyc]   = bus_req;
      obs_busy[cyc]  = busy;
      obs_tout[cyc]  = timeout;
      obs_over[cyc]  = overrun;
      obs_flags[cyc] = flags_q;
    end
    cyc++;
    // Model update for the coming edge.
    m_tout = 1'b0;
    if (m_mode == 0) begin
      if (le) begin
        m_q.delete();
        m_q.push_back(a[7:0]);
        if (NB == 2) m_q.push_back(a[15:8]);
        m_flags = f;
        m_over  = 1'b0;
        m_mode  = 1;
        m_wait  = 0;
      end
    end else if (m_mode == 1) begin
      if (le) m_over = 1'b1;
      if (g) begin
        m_mode = 2;
      end else begin
        m_wait++;
        if (m_wait == TO) begin
          m_mode = 0;
          m_tout = 1'b1;
        end
      end
    end else begin
      if (le) m_over = 1'b1;
      if (g) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_mode = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Asynchronous reset asserted in the middle of a cycle.
  task automatic mid_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_bus_oe", bus_oe, 1'b0);
    chk("rst_bus_data", bus_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flags_q", flags_q, 4'h0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    model_reset();
    latch_en = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Bytes driven (bus_oe=1) in log window [a,b), packed first byte lowest.
  task automatic sent_bytes(input int a, input int b, output int cnt, output logic [15:0] bytes);
    cnt   = 0;
    bytes = 16'h0000;
    for (int i = a; i < b; i++) begin
      if (obs_oe[i]) begin
        if (cnt < 2) bytes = bytes | (16'(obs_data[i]) << (8 * cnt));
        cnt++;
      end
    end
  endtask

  initial begin
    int          n;
    int          cnt;
    int          hits;
    logic [15:0] bytes;
    int          gmode;
    logic        g;

    reset     = 1'b0;
    latch_en  = 1'b0;
    alu_out   = 16'h0000;
    alu_flags = 4'h0;
    bus_grant = 1'b0;
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_bus_data", bus_data, 8'h00);
    chk("reset_flags_q", flags_q, 4'h0);
    chk("reset_overrun", overrun, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    cycle(1'b0, 16'h0, 4'h0, 1'b1);

    // Basic transfer with grant held high.
    n = cyc;
    cycle(1'b1, 16'hBEEF, 4'b0101, 1'b1);
    repeat (5) cycle(1'b0, 16'h0000, 4'h0, 1'b1);
    chk("beef_lo_oe", obs_oe[n+2], 1'b1);
    chk("beef_lo_byte", obs_data[n+2], 8'hEF);
    chk("beef_hi_byte", obs_data[n+3], (NB == 2) ? 16'h00BE : 16'h0000);
    chk("beef_busy_last", obs_busy[n+1+NB], 1'b1);
    chk("beef_busy_done", obs_busy[n+2+NB], 1'b0);
    chk("beef_flags", obs_flags[n+4], 4'b0101);
    sent_bytes(n, n + 6, cnt, bytes);
    chk("beef_count", cnt, NB);
    chk("beef_bytes", bytes, (NB == 2) ? 16'hBEEF : 16'h00EF);

    // Grant never arrives: abort after TO cycles of request.
    n = cyc;
    cycle(1'b1, 16'h1111, 4'b1001, 1'b0);
    repeat (TO + 4) cycle(1'b0, 16'h0000, 4'h0, 1'b0);
    hits = 0;
    for (int i = n + 1; i < n + TO + 5; i++) hits += int'(obs_req[i]);
    chk("to_req_cycles", hits, TO);
    hits = 0;
    for (int i = n + 1; i < n + TO + 5; i++) hits += int'(obs_tout[i]);
    chk("to_pulses", hits, 1);
    chk("to_pulse_time", obs_tout[n+TO+1], 1'b1);
    chk("to_idle", obs_busy[n+TO+1], 1'b0);
    chk("to_flags", obs_flags[n+TO+3], 4'b1001);

    // Grant dropped for three cycles while in LO.
    n = cyc;
    cycle(1'b1, 16'hBEEF, 4'b0101, 1'b1);
    cycle(1'b0, 16'h0000, 4'h0, 1'b1);
    repeat (3) cycle(1'b0, 16'h0000, 4'h0, 1'b0);
    repeat (4) cycle(1'b0, 16'h0000, 4'h0, 1'b1);
    for (int i = n + 2; i < n + 5; i++) chk("stall_oe", obs_oe[i], 1'b0);
    chk("stall_busy", obs_busy[n+4], 1'b1);
    chk("stall_lo_byte", obs_data[n+5], 8'hEF);
    sent_bytes(n, n + 9, cnt, bytes);
    chk("stall_count", cnt, NB);
    chk("stall_bytes", bytes, (NB == 2) ? 16'hBEEF : 16'h00EF);

    // Second capture request while busy is ignored and flagged.
    n = cyc;
    cycle(1'b1, 16'hBEEF, 4'b1010, 1'b0);
    cycle(1'b1, 16'h1234, 4'b0011, 1'b0);
    repeat (4) cycle(1'b0, 16'h0000, 4'h0, 1'b1);
    chk("ovr_set", obs_over[n+2], 1'b1);
    chk("ovr_sticky", obs_over[n+5], 1'b1);
    chk("ovr_flags", obs_flags[n+5], 4'b1010);
    sent_bytes(n, n + 6, cnt, bytes);
    chk("ovr_bytes", bytes, (NB == 2) ? 16'hBEEF : 16'h00EF);
    n = cyc;
    cycle(1'b1, 16'h5A3C, 4'b0110, 1'b1);
    repeat (4) cycle(1'b0, 16'h0000, 4'h0, 1'b1);
    chk("ovr_clear", obs_over[n+1], 1'b0);

    // Reset asserted mid-transfer, then a fresh transfer.
    cycle(1'b1, 16'hBEEF, 4'b0101, 1'b1);
    cycle(1'b0, 16'h0000, 4'h0, 1'b1);
    cycle(1'b0, 16'h0000, 4'h0, 1'b1);
    mid_reset();
    n = cyc;
    cycle(1'b1, 16'h00FF, 4'b1111, 1'b1);
    repeat (4) cycle(1'b0, 16'h0000, 4'h0, 1'b1);
    sent_bytes(n, n + 5, cnt, bytes);
    chk("rst_count", cnt, NB);
    chk("rst_bytes", bytes, 16'h00FF);

    // Randomized traffic against the reference model.
    gmode = 0;
    for (int i = 0; i < 1500; i++) begin
      if ((i % 64) == 0) gmode = $urandom_range(0, 2);
      case (gmode)
        0:       g = ($urandom_range(0, 7) != 0);
        1:       g = ($urandom_range(0, 1) != 0);
        default: g = ($urandom_range(0, 31) == 0);
      endcase
      if ($urandom_range(0, 399) == 0) begin
        mid_reset();
      end else begin
        cycle(($urandom_range(0, 5) == 0), 16'($urandom), 4'($urandom), g);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_latch.md
ALU_LATCH -- requirements
Module: alu_latch

Interface
REQ-001 Parameter TIMEOUT, default 16: cycles spent in REQ without bus_grant before abort; legal range 2..255.
REQ-002 clock  input  1  single system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 alu_out  input  16  ALU result; only bits captured on latch_en are used.
REQ-005 alu_flags  input  4  ALU flags: [0] carry, [1] zero, [2] neg, [3] overflow.
REQ-006 latch_en  input  1  single-cycle capture request from control unit.
REQ-007 bus_grant  input  1  databus arbiter grant.
REQ-008 bus_req  output  1  databus request.
REQ-009 bus_oe  output  1  databus drive enable.
REQ-010 bus_data  output  8  byte driven onto databus; 8'h00 whenever bus_oe=0.
REQ-011 flags_q  output  4  flags held from last accepted capture.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 timeout  output  1  one-cycle pulse on grant timeout abort.
REQ-014 overrun  output  1  sticky: latch_en arrived while busy.

Function
REQ-015 FSM states IDLE, REQ, LO, HI; IDLE after reset.
REQ-016 IDLE + latch_en: capture alu_out into res_q and alu_flags into flags_q, clear overrun, go REQ next cycle.
REQ-017 REQ: bus_req=1; wait counter increments each cycle with bus_grant=0; bus_grant=1 -> LO, counter cleared.
REQ-018 REQ with counter reaching TIMEOUT-1 and bus_grant=0: go IDLE, timeout=1 for one cycle, bus_req drops, res_q and flags_q retained.
REQ-019 LO: bus_req=1, bus_oe=bus_grant, bus_data=res_q[7:0] while bus_oe=1; advance only on a cycle with bus_grant=1.
REQ-020 HI: bus_req=1, bus_oe=bus_grant, bus_data=res_q[15:8] while bus_oe=1; on bus_grant=1 go IDLE.
REQ-021 Grant dropped in LO or HI: stall in that state with bus_oe=0, no timeout counting.
REQ-022 latch_en while busy: ignored, res_q/flags_q unchanged, overrun set to 1 next cycle.
REQ-023 latch_en in same cycle as final HI (or LO when HI disabled) transfer: ignored, sets overrun; IDLE acceptance only.
REQ-024 Latency: latch_en at cycle N with grant held high -> low byte on bus at N+2, high byte at N+3, busy low at N+4.
REQ-025 bus_oe and bus_req are registered-state decodes; no combinational path from alu_out to bus_data.

Reset
REQ-026 reset=0 forces asynchronously: state IDLE, res_q=16'h0000, flags_q=4'h0, counter=0, bus_req=0, bus_oe=0, bus_data=8'h00, busy=0, timeout=0, overrun=0.
REQ-027 Reset mid-transfer aborts with no further bus cycles; release resumes in IDLE.

Configuration
REQ-028 Macro ALU_LATCH_HI_BYTE_EN defined: LO -> HI -> IDLE, full 16-bit result transferred.
REQ-029 ALU_LATCH_HI_BYTE_EN undefined: HI state absent, LO -> IDLE on grant, res_q[15:8] not stored, single-byte transfer.

Structure
REQ-030 Shared package alu_pkg holds FSM state enum, flag bit index constants (FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3) and bus width constant 8.
REQ-031 One sub-module grant_timer (counter with clear, enable, TIMEOUT compare) is natural; remainder flat.

Verification
REQ-032 alu_out=16'hBEEF, flags=4'b0101, latch_en pulse, grant held 1 -> bus_data 8'hEF at N+2, 8'hBE at N+3, flags_q=4'b0101, busy low at N+4.
REQ-033 Grant held 0 with TIMEOUT=16 -> bus_req high 16 cycles, timeout pulse once, IDLE, flags_q retained.
REQ-034 Grant dropped for 3 cycles during LO -> bus_oe=0 for 3 cycles, then 8'hEF, then 8'hBE; no byte skipped or repeated.
REQ-035 Second latch_en (alu_out=16'h1234) during REQ -> overrun=1, transfer still sends EF/BE; next accepted latch_en clears overrun.
REQ-036 reset=0 asserted in HI -> all outputs zero immediately; after release, new latch_en of 16'h00FF transfers FF/00.
REQ-037 Build without ALU_LATCH_HI_BYTE_EN, alu_out=16'hBEEF -> only 8'hEF transferred, busy low at N+3.
